// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular round-robin AXI-Stream arbiter.
package axis_arb_pkg;

  // Arbiter FSM: IDLE spends one cycle picking an owner, BUSY forwards that owner's packet.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Reduce a sum of (index + step) back into 0..modulus-1. The caller guarantees
  // sum < 2*modulus, so a single conditional subtraction is enough, which keeps
  // the wrap correct for source counts that are not a power of two.
  function automatic int unsigned rr_wrap(input int unsigned sum, input int unsigned modulus);
    if (sum >= modulus) begin
      return sum - modulus;
    end
    return sum;
  endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first asserted request
// strictly after ptr, wrapping modulo NUM_SRC (ptr itself is checked last).
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  // cand[k] is the source index visited at scan position k, i.e. (ptr + k + 1) mod NUM_SRC.
  logic [ID_WIDTH-1:0] cand [NUM_SRC];
  logic [NUM_SRC-1:0]  hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      // One extra bit holds the un-reduced sum so the wrap never overflows.
      logic [ID_WIDTH:0] sum;
      assign sum      = {1'b0, ptr} + (ID_WIDTH + 1)'(gi + 1);
      assign cand[gi] = ID_WIDTH'(rr_wrap(32'(sum), 32'(NUM_SRC)));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  assign any = |req;

  // Priority scan: the lowest scan position with a request wins.
  always_comb begin
    idx = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: shares one AXI-Stream output between NUM_SRC sources.
// Arbitration is per packet and round-robin: an IDLE cycle picks the next
// requester after the previous owner, which then owns the output until its
// tlast beat handshakes. The data path is a zero-latency combinational mux.
// Optional build macro AXIS_ARB_ID_EN adds output m_id carrying the owner index.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SRC         = 4,
  parameter int ID_WIDTH        = $clog2(NUM_SRC)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SRC-1:0]                 s_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      s_data,
  input  logic [NUM_SRC*DATA_BYTE_WIDTH-1:0] s_keep,
  input  logic [NUM_SRC-1:0]                 s_last,
  output logic [NUM_SRC-1:0]                 s_ready,
  output logic                               m_valid,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [DATA_BYTE_WIDTH-1:0]         m_keep,
  output logic                               m_last,
`ifdef AXIS_ARB_ID_EN
  output logic [ID_WIDTH-1:0]                m_id,
`endif
  input  logic                               m_ready
);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;

  logic                pick_any;
  logic [ID_WIDTH-1:0] pick_idx;

  // Output is only driven while a packet is owned and reset is low, so the
  // downstream skid buffer sees zeros (never X) and no handshake during reset.
  logic                out_en;
  logic                beat_last_done;

  logic [DATA_WIDTH-1:0]      src_data [NUM_SRC];
  logic [DATA_BYTE_WIDTH-1:0] src_keep [NUM_SRC];

  // The previous owner is the round-robin pointer: scanning starts just after it.
  rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req (s_valid),
    .ptr (grant_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_keep[gi] = s_keep[gi*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
      // Only the owner sees downstream ready; everyone else is held off.
      assign s_ready[gi]  = out_en && (grant_q == ID_WIDTH'(gi)) && m_ready;
    end
  endgenerate

  assign out_en         = (state_q == ARB_BUSY) && !rst;
  assign beat_last_done = m_valid && m_ready && m_last;

  // Output mux: forward the owner's beat while BUSY, drive zeros otherwise.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_last  = 1'b0;
    if (out_en) begin
      m_valid = s_valid[grant_q];
      m_data  = src_data[grant_q];
      m_keep  = src_keep[grant_q];
      m_last  = s_last[grant_q];
    end
  end

`ifdef AXIS_ARB_ID_EN
  // grant never changes while BUSY, so m_id is stable across a packet.
  assign m_id = out_en ? grant_q : '0;
`else
  // No owner index output in this build.
`endif

  // Next-state logic: arbitrate in IDLE, release ownership on the tlast handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (beat_last_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and grant registers; reset points grant at the last source so source 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= ID_WIDTH'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter: directed scenarios plus a random
// phase, all checked every cycle against a packet-level reference model.
// Build with AXIS_ARB_ID_EN defined to also check m_id.
module tb_axis_pkt_rr_arbiter;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N*DW-1:0] s_data;
  logic [N*BW-1:0] s_keep;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [BW-1:0]   m_keep;
  logic            m_last;
  logic            m_ready;
`ifdef AXIS_ARB_ID_EN
  logic [IW-1:0]   m_id;
`endif

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(
    .DATA_WIDTH      (DW),
    .DATA_BYTE_WIDTH (BW),
    .NUM_SRC         (N),
    .ID_WIDTH        (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
`ifdef AXIS_ARB_ID_EN
    .m_id    (m_id),
`endif
    .m_ready (m_ready)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
  } beat_t;

  // Per-source pending beats; the front of each queue is what that source presents.
  beat_t srcq [N][$];
  logic [N-1:0] en;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: is a packet owned, and by whom (also the round-robin pointer).
  bit mdl_busy  = 1'b0;
  int mdl_owner = N - 1;

  // Observed output transfers.
  logic [DW-1:0] xfer_data  [$];
  int            xfer_cycle [$];
  int            pkt_src    [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        s_valid[i]          = 1'b1;
        s_data[i*DW +: DW]  = srcq[i][0].d;
        s_keep[i*BW +: BW]  = srcq[i][0].k;
        s_last[i]           = srcq[i][0].l;
      end else begin
        s_valid[i]          = 1'b0;
        s_data[i*DW +: DW]  = $urandom;
        s_keep[i*BW +: BW]  = BW'($urandom);
        s_last[i]           = 1'($urandom);
      end
    end
  endtask

  // Packet with data {src, tag, beat, random}.
  task automatic add_pkt(input int src, input int len, input int tag);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.d = {8'(src), 8'(tag), 8'(b), 8'($urandom)};
      x.k = BW'($urandom) | BW'(1);
      x.l = (b == len - 1);
      srcq[src].push_back(x);
    end
  endtask

  task automatic clear_logs();
    xfer_data.delete();
    xfer_cycle.delete();
    pkt_src.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit           exp_out;
    bit           exp_v;
    bit           xfer;
    bit           found;
    int           nxt;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    @(negedge clk);
    exp_out = !rst && mdl_busy;
    exp_v   = exp_out && s_valid[mdl_owner];
    exp_rdy = '0;
    if (exp_out && m_ready) exp_rdy[mdl_owner] = 1'b1;
    chk("m_valid", 64'(m_valid), 64'(exp_v));
    chk("s_ready", 64'(s_ready), 64'(exp_rdy));
    if (exp_v) begin
      b = srcq[mdl_owner][0];
      chk("m_data", 64'(m_data), 64'(b.d));
      chk("m_keep", 64'(m_keep), 64'(b.k));
      chk("m_last", 64'(m_last), 64'(b.l));
    end else if (!exp_out) begin
      chk("idle_zero", {m_data, 27'(m_keep), m_last}, 64'(0));
    end
`ifdef AXIS_ARB_ID_EN
    chk("m_id", 64'(m_id), exp_out ? 64'(mdl_owner) : 64'(0));
`endif
    xfer = exp_v && m_ready;
    if (m_valid && m_ready) begin
      xfer_data.push_back(m_data);
      xfer_cycle.push_back(cycle);
      if (m_last) pkt_src.push_back(int'(m_data[31:24]));
    end
    @(posedge clk);
    if (rst) begin
      mdl_busy  = 1'b0;
      mdl_owner = N - 1;
    end else if (mdl_busy) begin
      if (xfer) begin
        b = srcq[mdl_owner].pop_front();
        if (b.l) mdl_busy = 1'b0;
      end
    end else begin
      found = 1'b0;
      nxt   = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mdl_owner + k) % N;
        if (!found && s_valid[c]) begin
          found = 1'b1;
          nxt   = c;
        end
      end
      if (found) begin
        mdl_busy  = 1'b1;
        mdl_owner = nxt;
      end
    end
    cycle++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    step();
    step();
    rst = 1'b0;
    drive();
    clear_logs();
  endtask

  initial begin
    logic [DW-1:0] w1;
    logic [6:0]    rdy_pat;
    logic [DW-1:0] a_word;
    rst     = 1'b1;
    m_ready = 1'b0;
    en      = '0;
    s_valid = '0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = '0;

    // 1) After reset, sources 1 and 3 each offer a single-beat packet.
    do_reset();
    add_pkt(1, 1, 1);
    add_pkt(3, 1, 1);
    w1      = srcq[1][0].d;
    en      = '1;
    m_ready = 1'b1;
    drive();
    repeat (6) step();
    chk("s1_count", 64'(xfer_data.size()), 64'(2));
    chk("s1_first_word", (xfer_data.size() > 0) ? 64'(xfer_data[0]) : 64'hdead, 64'(w1));
    chk("s1_second_src", (pkt_src.size() > 1) ? 64'(pkt_src[1]) : 64'hdead, 64'(3));
    chk("s1_gap", (xfer_cycle.size() > 1) ? 64'(xfer_cycle[1] - xfer_cycle[0]) : 64'hdead, 64'(2));

    // 2) All sources stream 3-beat packets for 40 cycles: fair 0,1,2,3 rotation.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < N; s++) add_pkt(s, 3, p);
    en      = '1;
    m_ready = 1'b1;
    drive();
    repeat (40) step();
    chk("s2_pkts", 64'(pkt_src.size()), 64'(10));
    for (int i = 0; i < 10; i++)
      chk("s2_order", (pkt_src.size() > i) ? 64'(pkt_src[i]) : 64'hdead, 64'(i % N));

    // 3) Source 2 sends A0..A3 under a toggling m_ready while source 0 also requests.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      beat_t x;
      x.d = DW'(8'hA0 + b);
      x.k = '1;
      x.l = (b == 3);
      srcq[2].push_back(x);
    end
    add_pkt(0, 2, 3);
    en      = 4'b0100;
    m_ready = 1'b1;
    drive();
    step();
    en      = 4'b0101;
    rdy_pat = 7'b1101001;   // applied LSB first: 1,0,0,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      m_ready = rdy_pat[i];
      drive();
      step();
    end
    chk("s3_count", 64'(xfer_data.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      a_word = DW'(8'hA0 + i);
      chk("s3_word", (xfer_data.size() > i) ? 64'(xfer_data[i]) : 64'hdead, 64'(a_word));
    end
    m_ready = 1'b1;
    drive();
    repeat (4) step();

    // 4) Source 0 stalls mid-packet while source 1 waits its turn.
    do_reset();
    add_pkt(0, 4, 4);
    add_pkt(1, 1, 4);
    en      = 4'b0001;
    m_ready = 1'b1;
    drive();
    step();
    en = 4'b0011;
    drive();
    step();
    en = 4'b0010;
    drive();
    repeat (3) step();
    en = 4'b0011;
    drive();
    repeat (6) step();
    chk("s4_pkts", 64'(pkt_src.size()), 64'(2));
    chk("s4_first", (pkt_src.size() > 0) ? 64'(pkt_src[0]) : 64'hdead, 64'(0));
    chk("s4_second", (pkt_src.size() > 1) ? 64'(pkt_src[1]) : 64'hdead, 64'(1));

    // 5) Reset pulse at beat 2 of a 5-beat packet from source 3.
    do_reset();
    add_pkt(3, 5, 5);
    en      = 4'b1000;
    m_ready = 1'b1;
    drive();
    repeat (3) step();
    rst = 1'b1;
    drive();
    step();
    rst = 1'b0;
    srcq[3].delete();
    add_pkt(1, 2, 6);
    add_pkt(2, 1, 6);
    add_pkt(3, 1, 6);
    en = '1;
    clear_logs();
    drive();
    step();
    chk("s5_valid_after_rst", 64'(xfer_data.size()), 64'(0));
    repeat (8) step();
    chk("s5_first_grant", (pkt_src.size() > 0) ? 64'(pkt_src[0]) : 64'hdead, 64'(1));

    // 6) Random traffic: random packet lengths, source gaps and downstream backpressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (srcq[i].size() < 4 && $urandom_range(0, 3) == 0)
          add_pkt(i, int'($urandom_range(1, 5)), c);
      en      = N'($urandom) | N'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    chk("s6_progress", 64'(xfer_data.size() > 50), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Shares one AXI-Stream output (data/keep/last) between NUM_SRC upstream requesters.
- Arbitration is packet-granular and round-robin. Once a source is granted, it owns the output until its tlast beat completes a handshake.
- Sits upstream of the header-insert datapath. Its output feeds the stream skid buffer, so m_ready may be driven directly from that buffer's ready.

Parameters:
- DATA_WIDTH, 32, tdata width per source and on the output.
- DATA_BYTE_WIDTH, DATA_WIDTH/8, tkeep width.
- NUM_SRC, 4, number of requesting sources; legal range 2..16.
- ID_WIDTH, $clog2(NUM_SRC), width of the grant index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  NUM_SRC  per-source tvalid; bit i belongs to source i.
- s_data  in  NUM_SRC*DATA_WIDTH  source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_keep  in  NUM_SRC*DATA_BYTE_WIDTH  source i occupies [i*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH].
- s_last  in  NUM_SRC  per-source tlast.
- s_ready  out  NUM_SRC  per-source tready.
- m_valid  out  1  output tvalid.
- m_data  out  DATA_WIDTH  output tdata.
- m_keep  out  DATA_BYTE_WIDTH  output tkeep.
- m_last  out  1  output tlast.
- m_ready  in  1  downstream tready.

Behaviour:
- Registered state:
  - state: IDLE or BUSY.
  - grant: ID_WIDTH-bit index of the owning source.
- Reset: state=IDLE, grant=NUM_SRC-1, so source 0 has first priority after reset. During and after reset, m_valid=0 and s_ready=0.
- IDLE:
  - m_valid=0, all s_ready=0, m_data/m_keep/m_last=0.
  - If any s_valid bit is set, grant <= the first set index found scanning (grant+1), (grant+2), ... modulo NUM_SRC, and state <= BUSY.
  - If no s_valid bit is set, hold state and grant.
  - No beat is transferred in the arbitration cycle.
- BUSY (combinational datapath, zero-cycle latency through the mux):
  - m_valid = s_valid[grant]; m_data/m_keep/m_last = slice of source grant.
  - s_ready[grant] = m_ready; s_ready[j] = 0 for every j != grant.
  - A beat transfers when m_valid && m_ready.
  - A transferred beat with m_last=1 sets state <= IDLE. grant is held as the new round-robin pointer.
  - If the granted source drops s_valid mid-packet, the output idles (m_valid=0) and ownership is kept. There is no timeout.
  - Requests from other sources are ignored until return to IDLE.
- Throughput: one dead cycle per packet (the IDLE arbitration cycle). A single-beat packet therefore takes at most 50% of cycles.
- Fairness: with all sources continuously requesting, the grant order is 0,1,2,...,NUM_SRC-1,0,...
- Modulo wrap: computed in ID_WIDTH+1 bits, then reduced. Correct for NUM_SRC values that are not a power of 2.
- m_ready may toggle arbitrarily. The arbiter never changes grant while BUSY, so the AXI-Stream rules hold: no data change while valid && !ready.
- rst asserted mid-packet: the packet is abandoned, next state IDLE, grant=NUM_SRC-1. Sources see s_ready=0 from the next cycle.
- Output signals driven in IDLE are zero, not X, so downstream registers never capture X.

Optional Feature:
- Macro: AXIS_ARB_ID_EN.
- Defined:
  - Adds output port m_id (ID_WIDTH), driven with grant while BUSY and 0 in IDLE.
  - m_id is stable for every beat of a packet.
- Undefined: port m_id is absent; all other behaviour is identical.

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum typedef (ARB_IDLE=1'b0, ARB_BUSY=1'b1);
  - a localparam function for the modulo-NUM_SRC increment.
- Sub-module rr_pick (combinational):
  - inputs: req[NUM_SRC], ptr[ID_WIDTH].
  - outputs: any, idx[ID_WIDTH]. idx is the first set req after ptr, wrapping.
- The top level instantiates rr_pick once and holds the FSM, grant register and output mux.

Test Plan:
- Post-reset: s_valid=4'b1010, each source sending one 1-beat packet, m_ready=1 -> source 1 is granted first, then source 3. Expect m_data equal to the source-1 word, one idle cycle, then the source-3 word.
- All 4 sources stream continuous 3-beat packets, m_ready=1, for 40 cycles -> 10 packets, grant order 0,1,2,3,0,1,2,3,0,1. No beat interleaving within a packet.
- Source 2 sends 4 beats (0xA0..0xA3) with m_ready toggling 1,0,0,1,0,1,1 -> output order is 0xA0..0xA3. Data is stable during every stall. s_ready[2] mirrors m_ready and the other s_ready bits stay 0.
- Source 0 drops s_valid for 3 cycles mid-packet while source 1 is requesting -> m_valid=0 for those cycles and grant stays 0. Source 1 is granted only after source 0's tlast handshake.
- rst pulsed for one cycle at beat 2 of a 5-beat packet from source 3 -> next cycle s_ready=0 and m_valid=0. The next grant goes to the lowest-index requester.
- With AXIS_ARB_ID_EN defined, repeat the second scenario -> m_id equals the grant on every beat, and is 0 in IDLE.
